// File: rtl/subnode_link_pkg.sv
// rtl/subnode_link_pkg.sv - shared states, widths and defaults for the serial subnode link
package subnode_link_pkg;

  localparam int WORD_W       = 32;
  localparam int NB_DEF       = 4;
  localparam int NK_DEF       = 8;
  localparam int NR_DEF       = 14;
  localparam int WAIT_MAX_DEF = 64;
  localparam int WAIT_MAX_MIN = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_MSG,
    ST_SEND_KEY,
    ST_WAIT,
    ST_RECV,
    ST_DONE,
    ST_ERR
  } link_state_e;

  function automatic int msg_width(input int nb);
    return WORD_W * nb;
  endfunction

  function automatic int key_width(input int nk);
    return WORD_W * nk;
  endfunction

  // Bits needed to hold the value max_val itself, not just max_val-1.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/link_shift_reg.sv
// rtl/link_shift_reg.sv - left-shifting register with parallel load and serial in
module link_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[W-2:0], ser_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/subnode_master.sv
// rtl/subnode_master.sv - link master: shifts msg then key out, collects the serial result
module subnode_master
  import subnode_link_pkg::*;
#(
  parameter int  NK       = NK_DEF,
  parameter int  NB       = NB_DEF,
  parameter int  NR       = NR_DEF,
  parameter int  WAIT_MAX = WAIT_MAX_DEF,
  localparam int MSG_W    = msg_width(NB),
  localparam int KEY_W    = key_width(NK)
) (
  input  logic             in_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [KEY_W-1:0] key_in,
  input  logic             sdo_in,
  input  logic             data_done,
  output logic             cs,
  output logic             sdi,
  output logic             busy,
  output logic [MSG_W-1:0] result,
  output logic             result_valid,
  output logic             error
);

  localparam int BIT_W  = cnt_width((MSG_W > KEY_W) ? MSG_W : KEY_W);
  localparam int RX_W   = cnt_width(MSG_W);
  localparam int WAIT_W = cnt_width(WAIT_MAX);
  localparam logic [BIT_W-1:0]  MSG_LAST  = BIT_W'(MSG_W - 1);
  localparam logic [BIT_W-1:0]  KEY_LAST  = BIT_W'(KEY_W - 1);
  localparam logic [RX_W-1:0]   RX_LAST   = RX_W'(MSG_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  if (WAIT_MAX < WAIT_MAX_MIN || NR < 1) begin : g_param_check
    $error("subnode_master: WAIT_MAX must be >= 22 and NR >= 1");
  end

  link_state_e         state_q, state_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RX_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [MSG_W-1:0]    result_q, result_d;
  logic                cs_q, cs_d;
  logic                msg_load, key_load, msg_shift, key_shift, rx_shift;
  logic [MSG_W-1:0]    msg_sr, rx_sr;
  logic [KEY_W-1:0]    key_sr;
  logic                unused_sr_bits;

  link_shift_reg #(.W(MSG_W)) u_msg_tx (
    .clk_i(in_clk), .rst_ni(rst), .load_i(msg_load), .load_data_i(msg_in),
    .shift_i(msg_shift), .ser_i(1'b0), .data_o(msg_sr)
  );

  link_shift_reg #(.W(KEY_W)) u_key_tx (
    .clk_i(in_clk), .rst_ni(rst), .load_i(key_load), .load_data_i(key_in),
    .shift_i(key_shift), .ser_i(1'b0), .data_o(key_sr)
  );

  link_shift_reg #(.W(MSG_W)) u_res_rx (
    .clk_i(in_clk), .rst_ni(rst), .load_i(1'b0), .load_data_i('0),
    .shift_i(rx_shift), .ser_i(sdo_in), .data_o(rx_sr)
  );

  // Only the MSBs of the TX registers reach the wire; the RX MSB is shifted out on capture.
  assign unused_sr_bits = ^{msg_sr[MSG_W-2:0], key_sr[KEY_W-2:0], rx_sr[MSG_W-1]};

  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      rx_cnt_q   <= '0;
      result_q   <= '0;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      result_q   <= result_d;
      cs_q       <= cs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_SEND_MSG;
      ST_SEND_MSG: if (bit_cnt_q == MSG_LAST) state_d = ST_SEND_KEY;
      ST_SEND_KEY: if (bit_cnt_q == KEY_LAST) state_d = ST_WAIT;
      ST_WAIT: begin
        if (data_done) state_d = ST_RECV;
        else if (wait_cnt_q == WAIT_LAST) state_d = ST_ERR;
      end
      ST_RECV: begin
        if (!data_done) state_d = ST_ERR;
        else if (rx_cnt_q == RX_LAST) state_d = ST_DONE;
      end
      ST_DONE:     state_d = ST_IDLE;
      ST_ERR:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    result_d   = result_q;
    msg_load   = 1'b0;
    key_load   = 1'b0;
    msg_shift  = 1'b0;
    key_shift  = 1'b0;
    rx_shift   = 1'b0;
    // Registered from the next state so chip-select never glitches on a state decode.
    cs_d = !(state_d inside {ST_SEND_MSG, ST_SEND_KEY, ST_WAIT, ST_RECV});
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_load  = 1'b1;
          key_load  = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_SEND_MSG: begin
        if (bit_cnt_q == MSG_LAST) begin
          bit_cnt_d = '0;
        end else begin
          msg_shift = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_SEND_KEY: begin
        if (bit_cnt_q == KEY_LAST) begin
          wait_cnt_d = '0;
        end else begin
          key_shift = 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (data_done) begin
          rx_shift = 1'b1;
          rx_cnt_d = RX_W'(1);
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_RECV: begin
        if (data_done) begin
          rx_shift = 1'b1;
          rx_cnt_d = rx_cnt_q + 1'b1;
          if (rx_cnt_q == RX_LAST) result_d = {rx_sr[MSG_W-2:0], sdo_in};
        end
      end
      default: ;
    endcase
  end

  assign cs           = cs_q;
  assign sdi          = (state_q == ST_SEND_MSG) ? msg_sr[MSG_W-1] :
                        (state_q == ST_SEND_KEY) ? key_sr[KEY_W-1] : 1'b0;
  assign busy         = (state_q != ST_IDLE);
  assign result       = result_q;
  assign result_valid = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);

endmodule
